// File: rtl/updown_counter_sequencer.sv
// ---------------------------------------------------------------------------
// updown_counter_sequencer
//
// Command-driven controller for a loadable up/down counter. A command
// (start value, direction, step count) is accepted over a valid/ready
// handshake. The controller preloads the counter, steps it the requested
// number of times (pausing on hold, stopping early on abort), then reports
// the final counter value together with wrap and abort flags.
//
// States
//   IDLE | waiting for a command, cmd_ready high
//   LOAD | counter preloaded with the latched start value
//   RUN  | stepping; abort > hold > step
//   DONE | counter idle, final value captured, done pulses next cycle
//
// Ports
//   clk, reset            clock and async active-high reset (shared with counter)
//   cmd_valid/cmd_ready   command handshake
//   cmd_start/up/len      command fields (len = number of steps, 0 = load only)
//   hold, abort           RUN-only pause / early termination
//   ctr_load/data/count_up/on  combinational controls to the counter
//   ctr_count             current counter value
//   busy                  high in every state except IDLE
//   done                  one-cycle registered completion pulse
//   result/wrapped/aborted  registered completion status, held until next DONE
// ---------------------------------------------------------------------------
module updown_counter_sequencer #(
    parameter int WIDTH = 3,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic             cmd_up,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             hold,
    input  logic             abort,
    output logic             ctr_load,
    output logic [WIDTH-1:0] ctr_data,
    output logic             ctr_count_up,
    output logic             ctr_on,
    input  logic [WIDTH-1:0] ctr_count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             wrapped,
    output logic             aborted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] remaining;
    logic [WIDTH-1:0] start_q;
    logic             up_q;
    logic [LEN_W-1:0] len_q;
    logic             wrap_acc;
    logic             abort_acc;

    logic             accept;
    logic             step;
    logic             set_abort;
    logic             wrap_hit;

    // A step wraps when the counter is currently at the end it is moving away from.
    assign wrap_hit = up_q ? (ctr_count == {WIDTH{1'b1}}) : (ctr_count == {WIDTH{1'b0}});

    always_comb begin
        state_next   = state;
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        ctr_load     = 1'b0;
        ctr_data     = '0;
        ctr_on       = 1'b0;
        ctr_count_up = up_q;
        accept       = 1'b0;
        step         = 1'b0;
        set_abort    = 1'b0;

        case (state)
            S_IDLE: begin
                cmd_ready    = 1'b1;
                busy         = 1'b0;
                ctr_count_up = 1'b0;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                ctr_load = 1'b1;
                ctr_data = start_q;
                if (len_q == '0) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    set_abort  = 1'b1;
                    state_next = S_DONE;
                end else if (!hold) begin
                    ctr_on = 1'b1;
                    step   = 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            start_q   <= '0;
            up_q      <= 1'b0;
            len_q     <= '0;
            wrap_acc  <= 1'b0;
            abort_acc <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            wrapped   <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == S_DONE);

            if (accept) begin
                start_q   <= cmd_start;
                up_q      <= cmd_up;
                len_q     <= cmd_len;
                wrap_acc  <= 1'b0;
                abort_acc <= 1'b0;
            end

            if (state == S_LOAD) begin
                remaining <= len_q;
            end

            if (step) begin
                remaining <= remaining - LEN_W'(1);
                if (wrap_hit) begin
                    wrap_acc <= 1'b1;
                end
            end

            if (set_abort) begin
                abort_acc <= 1'b1;
            end

            // Status outputs only change here so they stay stable between completions.
            if (state == S_DONE) begin
                result  <= ctr_count;
                wrapped <= wrap_acc;
                aborted <= abort_acc;
            end
        end
    end

endmodule

// File: tb/tb_updown_counter_sequencer.sv
module tb_updown_counter_sequencer;

    localparam int WIDTH = 3;
    localparam int LEN_W = 4;
    localparam int SCHED = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start;
    logic             cmd_up;
    logic [LEN_W-1:0] cmd_len;
    logic             hold;
    logic             abort;
    logic             ctr_load;
    logic [WIDTH-1:0] ctr_data;
    logic             ctr_count_up;
    logic             ctr_on;
    logic [WIDTH-1:0] ctr_count;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             wrapped;
    logic             aborted;

    int n_checks = 0;
    int n_errors = 0;

    bit hold_s  [SCHED];
    bit abort_s [SCHED];

    always #5 clk = ~clk;

    updown_counter_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_start    (cmd_start),
        .cmd_up       (cmd_up),
        .cmd_len      (cmd_len),
        .hold         (hold),
        .abort        (abort),
        .ctr_load     (ctr_load),
        .ctr_data     (ctr_data),
        .ctr_count_up (ctr_count_up),
        .ctr_on       (ctr_on),
        .ctr_count    (ctr_count),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .wrapped      (wrapped),
        .aborted      (aborted)
    );

    // The 3-bit loadable up/down counter that the controller drives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            ctr_count <= '0;
        else if (ctr_load)    ctr_count <= ctr_data;
        else if (ctr_on)      ctr_count <= ctr_count_up ? ctr_count + 3'd1 : ctr_count - 3'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural expectation: walk the hold/abort schedule one RUN cycle at a
    // time, moving an integer value modulo 8 on every non-held cycle.
    task automatic model(input int start, input bit up, input int len,
                         output int res, output bit wr, output bit ab, output int run_cycles);
        int v;
        int steps;
        v = start; steps = 0; wr = 0; ab = 0; run_cycles = 0;
        if (len != 0) begin
            for (int i = 0; i < SCHED; i++) begin
                run_cycles = i + 1;
                if (abort_s[i]) begin
                    ab = 1;
                    break;
                end
                if (!hold_s[i]) begin
                    if (up) begin
                        if (v + 1 > 7) wr = 1;
                        v = (v + 1) % 8;
                    end else begin
                        if (v - 1 < 0) wr = 1;
                        v = (v + 7) % 8;
                    end
                    steps++;
                    if (steps == len) break;
                end
            end
        end
        res = v;
    endtask

    task automatic clear_sched();
        for (int i = 0; i < SCHED; i++) begin
            hold_s[i]  = 0;
            abort_s[i] = 0;
        end
    endtask

    task automatic random_sched(input int hold_pct, input int abort_pct);
        for (int i = 0; i < SCHED; i++) begin
            hold_s[i]  = (i < 40) && ($urandom_range(0, 99) < hold_pct);
            abort_s[i] = (i < 40) && ($urandom_range(0, 99) < abort_pct);
        end
    endtask

    // Called just after an active edge with the DUT in IDLE. Returns just after
    // the edge where done is seen, so a following call is back-to-back.
    task automatic run_cmd(input string name, input int start, input bit up, input int len,
                           input bit keep_valid);
        int  exp_res;
        bit  exp_wr;
        bit  exp_ab;
        int  rc;
        int  c;
        int  tv;
        int  idx;
        bit  exp_on;
        bit  seen;

        model(start, up, len, exp_res, exp_wr, exp_ab, rc);

        check_eq({name, ".ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_start = 3'(start);
        cmd_up    = up;
        cmd_len   = 4'(len);
        hold      = 1'($urandom_range(0, 1));
        abort     = 1'($urandom_range(0, 1));
        @(posedge clk); #1;

        cmd_valid = keep_valid;
        cmd_start = 3'($urandom_range(0, 7));
        cmd_up    = 1'($urandom_range(0, 1));
        cmd_len   = 4'($urandom_range(0, 15));

        c    = 1;
        tv   = start;
        seen = 0;
        check_eq({name, ".load"},      32'(ctr_load), 32'd1);
        check_eq({name, ".load_data"}, 32'(ctr_data), 32'(start));
        check_eq({name, ".load_on"},   32'(ctr_on),   32'd0);
        check_eq({name, ".load_busy"}, 32'(busy),     32'd1);
        check_eq({name, ".done_pulse_width"}, 32'(done), 32'd0);

        while (c < 100) begin
            if (done) begin
                seen = 1;
                break;
            end
            idx = c - 2;
            if (idx >= 0 && idx < rc) begin
                hold   = hold_s[idx];
                abort  = abort_s[idx];
                exp_on = !abort_s[idx] && !hold_s[idx];
                #1;
                check_eq({name, ".run_on"},    32'(ctr_on),    32'(exp_on));
                check_eq({name, ".run_count"}, 32'(ctr_count), 32'(tv));
                check_eq({name, ".run_load"},  32'(ctr_load),  32'd0);
                if (exp_on) begin
                    check_eq({name, ".run_dir"}, 32'(ctr_count_up), 32'(up));
                    tv = up ? (tv + 1) % 8 : (tv + 7) % 8;
                end
            end else if (c >= 2) begin
                // Outside RUN, hold/abort must have no effect.
                hold  = 1'($urandom_range(0, 1));
                abort = 1'($urandom_range(0, 1));
                #1;
                check_eq({name, ".idle_on"}, 32'(ctr_on), 32'd0);
            end
            @(posedge clk); #1;
            c++;
        end

        cmd_valid = 1'b0;
        hold      = 1'b0;
        abort     = 1'b0;
        check_eq({name, ".done_seen"},    32'(seen),      32'd1);
        check_eq({name, ".done_cycle"},   32'(c),         32'(3 + rc));
        check_eq({name, ".result"},       32'(result),    32'(exp_res));
        check_eq({name, ".wrapped"},      32'(wrapped),   32'(exp_wr));
        check_eq({name, ".aborted"},      32'(aborted),   32'(exp_ab));
        check_eq({name, ".ready_at_done"},32'(cmd_ready), 32'd1);
        check_eq({name, ".busy_at_done"}, 32'(busy),      32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_start = 3'd5;
        cmd_up    = 1'b1;
        cmd_len   = 4'd3;
        hold      = 1'b0;
        abort     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.ready",   32'(cmd_ready),    32'd1);
        check_eq("rst.busy",    32'(busy),         32'd0);
        check_eq("rst.done",    32'(done),         32'd0);
        check_eq("rst.result",  32'(result),       32'd0);
        check_eq("rst.wrapped", 32'(wrapped),      32'd0);
        check_eq("rst.aborted", 32'(aborted),      32'd0);
        check_eq("rst.load",    32'(ctr_load),     32'd0);
        check_eq("rst.on",      32'(ctr_on),       32'd0);
        check_eq("rst.dir",     32'(ctr_count_up), 32'd0);
        check_eq("rst.data",    32'(ctr_data),     32'd0);

        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst.busy", 32'(busy), 32'd0);

        clear_sched();
        run_cmd("up_plain", 5, 1, 2, 0);

        clear_sched();
        run_cmd("up_wrap", 6, 1, 3, 1);

        clear_sched();
        hold_s[1] = 1;
        hold_s[2] = 1;
        run_cmd("down_hold_wrap", 1, 0, 2, 0);

        clear_sched();
        run_cmd("load_only", 3, 1, 0, 0);

        clear_sched();
        abort_s[1] = 1;
        run_cmd("abort", 2, 1, 5, 0);

        // Reset in the middle of RUN.
        check_eq("rst_mid.ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_start = 3'd0;
        cmd_up    = 1'b1;
        cmd_len   = 4'd7;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_mid.running", 32'(ctr_on), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_mid.on",      32'(ctr_on),       32'd0);
        check_eq("rst_mid.dir",     32'(ctr_count_up), 32'd0);
        check_eq("rst_mid.load",    32'(ctr_load),     32'd0);
        check_eq("rst_mid.busy",    32'(busy),         32'd0);
        check_eq("rst_mid.done",    32'(done),         32'd0);
        check_eq("rst_mid.result",  32'(result),       32'd0);
        check_eq("rst_mid.aborted", 32'(aborted),      32'd0);
        check_eq("rst_mid.ready",   32'(cmd_ready),    32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("rst_mid.no_done", 32'(done), 32'd0);
            check_eq("rst_mid.idle",    32'(busy), 32'd0);
        end

        clear_sched();
        run_cmd("after_rst", 4, 0, 6, 0);

        for (int n = 0; n < 40; n++) begin
            random_sched($urandom_range(0, 40), (n % 4 == 0) ? 6 : 0);
            run_cmd("rand", $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
